instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the core's 8-bit decode field. Takes a decode byte {instr_type[3:0], instr_code[3:0]} plus operand fields and produces the 32-bit RV32I instruction word.
- Used by the self-test instruction generator and the debug-injection path to build legal instructions from the same type/code namespace the decoder emits.
- Valid/ready on both sides, with a 2-entry output buffer for full throughput.

Parameters:
- XLEN, 32, instruction/immediate width; only 32 supported.
- DEPTH, 2, output buffer entries; only 2 supported.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready at posedge clk
- in_decode  in  8  {type[7:4], code[3:0]}
- in_rd  in  5  destination register
- in_rs1  in  5  source 1, or zimm for CSR*I
- in_rs2  in  5  source 2
- in_imm  in  32  immediate; CSR address in [11:0]; FENCE pred/succ in [7:0]
- out_valid  out  1  encoded word valid
- out_ready  in  1  consumer accepts when out_valid & out_ready
- out_instr  out  32  encoded instruction
- out_illegal  out  1  decode pair not encodable; out_instr = 0x00000000
- out_misalign  out  1  B/J request with in_imm[0]=1; bit dropped, word still emitted
- err_count  out  8  saturating count of accepted illegal requests

Behaviour:
- Reset (synchronous, rst=1 at posedge): buffer emptied; out_valid=0, out_instr=0, out_illegal=0, out_misalign=0, err_count=0; in_ready=1 in the cycle after reset.
- Encoding is combinational from the in_* fields. The result plus its flags is written into the buffer tail on acceptance.
- Latency: a request accepted at edge N gives out_valid=1 after edge N, so it is visible in cycle N+1.
- in_ready = (occupancy < 2); it does not depend on in_valid.
- out_* always present the buffer head. The head pops on out_valid & out_ready.
- Simultaneous push and pop: occupancy unchanged, order preserved.
- Push when full cannot occur because in_ready=0.
- The buffer is FIFO: words leave in acceptance order. out_* are held stable while out_valid=1 and out_ready=0.
- Encoding table (type/code -> mnemonic):
  - 1/0..C: SLLI, SRLI, SRAI, ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND. Shift amount is in_imm[4:0]; funct7 is 0x20 for SRAI/SUB/SRA, else 0.
  - 2/0..A: JALR, LB, LH, LW, LBU, ADDI, SLTI, SLTIU, XORI, ORI, ANDI. 2/5 always encodes ADDI; LHU is not encodable.
  - 3/0..2: SB, SH, SW.
  - 4/0..5: BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - 5/0..1: LUI, AUIPC, using in_imm[31:12].
  - 6/0: JAL.
  - 7/0..3: FENCE (pred/succ from in_imm[7:0] into [27:20], other fields 0), FENCE.I = 0x0000100F, ECALL = 0x00000073, EBREAK = 0x00100073.
  - 8/0..4: CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, with csr = in_imm[11:0] and rs1 field = in_rs1.
  - Every other pair is illegal.
- Immediate placement follows standard I/S/B/U/J formats. B and J use in_imm[12:1] and in_imm[20:1] respectively; upper immediate bits beyond the format width are ignored, with no flag.
- Unused register fields (e.g. rs2 on I-type) are emitted as 0, not as port values.
- err_count increments once per accepted illegal request and saturates at 0xFF. It is not affected by out_misalign.
- Reset mid-stream: buffered words are discarded and never presented.

Test Plan:
- ADD: decode 0x13, rd=1, rs1=2, rs2=3, out_ready=1 -> out_instr=0x003100B3 one cycle after acceptance, flags 0.
- Immediates:
  - ADDI: decode 0x25, rd=5, rs1=0, imm=0xFFF -> 0xFFF00293.
  - BEQ: decode 0x40, rs1=1, rs2=2, imm=0x10 -> 0x00208863.
  - JAL: decode 0x60, rd=1, imm=0x801 -> 0x001000EF with out_misalign=1.
- Backpressure: out_ready=0 with in_valid=1 for 4 cycles -> exactly 2 accepted, in_ready=0 from the third cycle, head word held stable. Then out_ready=1 -> both words drain in order and in_ready returns to 1.
- Illegal: decode 0x2F, then 0x90, then 0x00 -> each gives out_instr=0 with out_illegal=1, and err_count=3. Feed 260 illegal requests -> err_count=0xFF.
- Fixed words:
  - FENCE.I 0x71 -> 0x0000100F.
  - ECALL 0x72 -> 0x00000073.
  - EBREAK 0x73 -> 0x00100073.
  - CSRRSI 0x84, rd=3, rs1=5, imm=0x300 -> 0x3002E1F3.
- Reset with 2 words buffered -> out_valid=0 and err_count=0 the next cycle, and no stale word appears afterward.

Source files
------------

// File: rtl/instr_encoder.sv
// RV32I encoder: maps a decode byte {type, code} plus operand fields to a 32-bit
// instruction word, delivered through a small valid/ready FIFO with error flags.
module instr_encoder #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [7:0]      in_decode,
    input  logic [4:0]      in_rd,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic [XLEN-1:0] in_imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic            out_illegal,
    output logic            out_misalign,
    output logic [7:0]      err_count
);

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = XLEN + 2;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] F7_ZERO   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;

    function automatic logic [31:0] r_word(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] i_word(input logic [11:0] imm12, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd,
                                           input logic [6:0] op);
        return {imm12, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] s_word(input logic [11:0] imm12, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3);
        return {imm12[11:5], rs2, rs1, f3, imm12[4:0], OP_STORE};
    endfunction

    function automatic logic [31:0] b_word(input logic [12:1] off, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3);
        return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], OP_BRANCH};
    endfunction

    logic [3:0]  dec_type;
    logic [3:0]  dec_code;
    logic [31:0] enc_instr;
    logic        enc_illegal;
    logic        enc_misalign;

    assign dec_type = in_decode[7:4];
    assign dec_code = in_decode[3:0];

    // Unused register fields are tied to zero rather than passed through.
    always_comb begin
        enc_instr    = 32'h0;
        enc_illegal  = 1'b0;
        enc_misalign = 1'b0;
        case (dec_type)
            4'h1: begin
                case (dec_code)
                    4'h0: enc_instr = r_word(F7_ZERO, in_imm[4:0], in_rs1, 3'b001, in_rd, OP_IMM);
                    4'h1: enc_instr = r_word(F7_ZERO, in_imm[4:0], in_rs1, 3'b101, in_rd, OP_IMM);
                    4'h2: enc_instr = r_word(F7_ALT,  in_imm[4:0], in_rs1, 3'b101, in_rd, OP_IMM);
                    4'h3: enc_instr = r_word(F7_ZERO, in_rs2, in_rs1, 3'b000, in_rd, OP_REG);
                    4'h4: enc_instr = r_word(F7_ALT,  in_rs2, in_rs1, 3'b000, in_rd, OP_REG);
                    4'h5: enc_instr = r_word(F7_ZERO, in_rs2, in_rs1, 3'b001, in_rd, OP_REG);
                    4'h6: enc_instr = r_word(F7_ZERO, in_rs2, in_rs1, 3'b010, in_rd, OP_REG);
                    4'h7: enc_instr = r_word(F7_ZERO, in_rs2, in_rs1, 3'b011, in_rd, OP_REG);
                    4'h8: enc_instr = r_word(F7_ZERO, in_rs2, in_rs1, 3'b100, in_rd, OP_REG);
                    4'h9: enc_instr = r_word(F7_ZERO, in_rs2, in_rs1, 3'b101, in_rd, OP_REG);
                    4'hA: enc_instr = r_word(F7_ALT,  in_rs2, in_rs1, 3'b101, in_rd, OP_REG);
                    4'hB: enc_instr = r_word(F7_ZERO, in_rs2, in_rs1, 3'b110, in_rd, OP_REG);
                    4'hC: enc_instr = r_word(F7_ZERO, in_rs2, in_rs1, 3'b111, in_rd, OP_REG);
                    default: enc_illegal = 1'b1;
                endcase
            end
            4'h2: begin
                case (dec_code)
                    4'h0: enc_instr = i_word(in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR);
                    4'h1: enc_instr = i_word(in_imm[11:0], in_rs1, 3'b000, in_rd, OP_LOAD);
                    4'h2: enc_instr = i_word(in_imm[11:0], in_rs1, 3'b001, in_rd, OP_LOAD);
                    4'h3: enc_instr = i_word(in_imm[11:0], in_rs1, 3'b010, in_rd, OP_LOAD);
                    4'h4: enc_instr = i_word(in_imm[11:0], in_rs1, 3'b100, in_rd, OP_LOAD);
                    4'h5: enc_instr = i_word(in_imm[11:0], in_rs1, 3'b000, in_rd, OP_IMM);
                    4'h6: enc_instr = i_word(in_imm[11:0], in_rs1, 3'b010, in_rd, OP_IMM);
                    4'h7: enc_instr = i_word(in_imm[11:0], in_rs1, 3'b011, in_rd, OP_IMM);
                    4'h8: enc_instr = i_word(in_imm[11:0], in_rs1, 3'b100, in_rd, OP_IMM);
                    4'h9: enc_instr = i_word(in_imm[11:0], in_rs1, 3'b110, in_rd, OP_IMM);
                    4'hA: enc_instr = i_word(in_imm[11:0], in_rs1, 3'b111, in_rd, OP_IMM);
                    default: enc_illegal = 1'b1;
                endcase
            end
            4'h3: begin
                case (dec_code)
                    4'h0: enc_instr = s_word(in_imm[11:0], in_rs2, in_rs1, 3'b000);
                    4'h1: enc_instr = s_word(in_imm[11:0], in_rs2, in_rs1, 3'b001);
                    4'h2: enc_instr = s_word(in_imm[11:0], in_rs2, in_rs1, 3'b010);
                    default: enc_illegal = 1'b1;
                endcase
            end
            4'h4: begin
                enc_misalign = in_imm[0];
                case (dec_code)
                    4'h0: enc_instr = b_word(in_imm[12:1], in_rs2, in_rs1, 3'b000);
                    4'h1: enc_instr = b_word(in_imm[12:1], in_rs2, in_rs1, 3'b001);
                    4'h2: enc_instr = b_word(in_imm[12:1], in_rs2, in_rs1, 3'b100);
                    4'h3: enc_instr = b_word(in_imm[12:1], in_rs2, in_rs1, 3'b101);
                    4'h4: enc_instr = b_word(in_imm[12:1], in_rs2, in_rs1, 3'b110);
                    4'h5: enc_instr = b_word(in_imm[12:1], in_rs2, in_rs1, 3'b111);
                    default: begin
                        enc_illegal  = 1'b1;
                        enc_misalign = 1'b0;
                    end
                endcase
            end
            4'h5: begin
                case (dec_code)
                    4'h0: enc_instr = {in_imm[31:12], in_rd, OP_LUI};
                    4'h1: enc_instr = {in_imm[31:12], in_rd, OP_AUIPC};
                    default: enc_illegal = 1'b1;
                endcase
            end
            4'h6: begin
                if (dec_code == 4'h0) begin
                    enc_instr    = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
                    enc_misalign = in_imm[0];
                end else begin
                    enc_illegal = 1'b1;
                end
            end
            4'h7: begin
                case (dec_code)
                    4'h0: enc_instr = {4'h0, in_imm[7:0], 5'h0, 3'b000, 5'h0, OP_FENCE};
                    4'h1: enc_instr = 32'h0000100F;
                    4'h2: enc_instr = 32'h00000073;
                    4'h3: enc_instr = 32'h00100073;
                    default: enc_illegal = 1'b1;
                endcase
            end
            4'h8: begin
                case (dec_code)
                    4'h0: enc_instr = i_word(in_imm[11:0], in_rs1, 3'b001, in_rd, OP_SYSTEM);
                    4'h1: enc_instr = i_word(in_imm[11:0], in_rs1, 3'b010, in_rd, OP_SYSTEM);
                    4'h2: enc_instr = i_word(in_imm[11:0], in_rs1, 3'b011, in_rd, OP_SYSTEM);
                    4'h3: enc_instr = i_word(in_imm[11:0], in_rs1, 3'b101, in_rd, OP_SYSTEM);
                    4'h4: enc_instr = i_word(in_imm[11:0], in_rs1, 3'b110, in_rd, OP_SYSTEM);
                    default: enc_illegal = 1'b1;
                endcase
            end
            default: enc_illegal = 1'b1;
        endcase
    end

    logic [ENTRY_W-1:0] slot_q [DEPTH];
    logic [ENTRY_W-1:0] head_word;
    logic [PTR_W-1:0]   head_reg;
    logic [PTR_W-1:0]   tail_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [7:0]         err_count_reg;
    logic               push;
    logic               pop;

    assign in_ready  = (count_reg < CNT_W'(DEPTH));
    assign out_valid = (count_reg != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign head_word = slot_q[head_reg];

    // Outputs read zero while empty so discarded entries never leak out.
    assign out_instr    = out_valid ? head_word[XLEN-1:0] : '0;
    assign out_illegal  = out_valid & head_word[XLEN];
    assign out_misalign = out_valid & head_word[XLEN+1];
    assign err_count    = err_count_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [ENTRY_W-1:0] entry_reg;
            always_ff @(posedge clk) begin
                if (push && (tail_reg == PTR_W'(gi))) begin
                    entry_reg <= {enc_misalign, enc_illegal, enc_instr};
                end
            end
            assign slot_q[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= '0;
            err_count_reg <= 8'h00;
        end else begin
            if (push) begin
                tail_reg <= (tail_reg == PTR_W'(DEPTH - 1)) ? '0 : tail_reg + 1'b1;
            end
            if (pop) begin
                head_reg <= (head_reg == PTR_W'(DEPTH - 1)) ? '0 : head_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (push && enc_illegal && (err_count_reg != 8'hFF)) begin
                err_count_reg <= err_count_reg + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-computed instruction words, backpressure,
// illegal-count saturation and reset while words are buffered.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_decode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_illegal;
    logic        out_misalign;
    logic [7:0]  err_count;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          accepted;
    logic [3:0]  rdy_seen;

    always #5 clk = ~clk;

    instr_encoder #(.XLEN(32), .DEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_decode    (in_decode),
        .in_rd        (in_rd),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_imm       (in_imm),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_illegal  (out_illegal),
        .out_misalign (out_misalign),
        .err_count    (err_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] dec, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm);
        in_decode = dec;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
    endtask

    // One request into an empty buffer with out_ready=1; word checked the cycle after acceptance.
    task automatic xact(input string tag, input logic [7:0] dec, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                        input logic [31:0] exp_w, input logic exp_ill, input logic exp_mis);
        @(negedge clk);
        check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        drive(dec, rd, rs1, rs2, imm);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_instr"}, out_instr, exp_w);
        check_eq({tag, "_illegal"}, 32'(out_illegal), 32'(exp_ill));
        check_eq({tag, "_misalign"}, 32'(out_misalign), 32'(exp_mis));
        $display("xact %s: decode=0x%02h instr=0x%08h ill=%0d mis=%0d err=%0d",
                 tag, dec, out_instr, out_illegal, out_misalign, err_count);
        @(posedge clk);
        #1;
        check_eq({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive(8'h00, 5'd0, 5'd0, 5'd0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_instr", out_instr, 32'h0);
        check_eq("rst_err_count", 32'(err_count), 32'd0);
        $display("xact reset: out_valid=%0d in_ready=%0d", out_valid, in_ready);

        xact("ADD",    8'h13, 5'd1,  5'd2, 5'd3,  32'h0000_0000, 32'h003100B3, 1'b0, 1'b0);
        xact("ADDI",   8'h25, 5'd5,  5'd0, 5'd7,  32'h0000_0FFF, 32'hFFF00293, 1'b0, 1'b0);
        xact("BEQ",    8'h40, 5'd9,  5'd1, 5'd2,  32'h0000_0010, 32'h00208863, 1'b0, 1'b0);
        xact("JAL",    8'h60, 5'd1,  5'd4, 5'd5,  32'h0000_0801, 32'h001000EF, 1'b0, 1'b1);
        check_eq("misalign_no_err", 32'(err_count), 32'd0);
        xact("SRAI",   8'h12, 5'd7,  5'd8, 5'd9,  32'h0000_0045, 32'h40545393, 1'b0, 1'b0);
        xact("SW",     8'h32, 5'd9,  5'd2, 5'd3,  32'h0000_07F4, 32'h7E312A23, 1'b0, 1'b0);
        xact("BGEU",   8'h45, 5'd0,  5'd3, 5'd4,  32'h0000_1FFE, 32'hFE41FFE3, 1'b0, 1'b0);
        xact("LUI",    8'h50, 5'd10, 5'd1, 5'd1,  32'h1234_5FFF, 32'h12345537, 1'b0, 1'b0);
        xact("FENCE",  8'h70, 5'd1,  5'd1, 5'd1,  32'h0000_00FF, 32'h0FF0000F, 1'b0, 1'b0);
        xact("FENCEI", 8'h71, 5'd3,  5'd3, 5'd3,  32'h0000_0000, 32'h0000100F, 1'b0, 1'b0);
        xact("ECALL",  8'h72, 5'd3,  5'd3, 5'd3,  32'h0000_0000, 32'h00000073, 1'b0, 1'b0);
        xact("EBREAK", 8'h73, 5'd0,  5'd0, 5'd0,  32'h0000_0000, 32'h00100073, 1'b0, 1'b0);
        xact("CSRRW",  8'h80, 5'd1,  5'd2, 5'd6,  32'h0000_0305, 32'h305110F3, 1'b0, 1'b0);
        xact("CSRRSI", 8'h84, 5'd3,  5'd5, 5'd0,  32'h0000_0300, 32'h3002E1F3, 1'b0, 1'b0);

        // Backpressure: four offered cycles with the consumer stalled.
        accepted = 0;
        rdy_seen = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            out_ready   = 1'b0;
            rdy_seen[i] = in_ready;
            if (in_ready) accepted++;
            if (i >= 1) check_eq("BP_head_hold", out_instr, 32'h003100B3);
            case (i)
                0:       drive(8'h13, 5'd1, 5'd2, 5'd3, 32'h0);
                1:       drive(8'h14, 5'd4, 5'd5, 5'd6, 32'h0);
                default: drive(8'h18, 5'd7, 5'd7, 5'd7, 32'h0);
            endcase
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("BP_accepted", 32'(accepted), 32'd2);
        check_eq("BP_ready_cyc3", 32'(rdy_seen[2]), 32'd0);
        check_eq("BP_ready_cyc4", 32'(rdy_seen[3]), 32'd0);
        check_eq("BP_head_final", out_instr, 32'h003100B3);
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("BP_second_valid", 32'(out_valid), 32'd1);
        check_eq("BP_second_word", out_instr, 32'h40628233);
        @(negedge clk);
        check_eq("BP_empty", 32'(out_valid), 32'd0);
        check_eq("BP_ready_back", 32'(in_ready), 32'd1);
        $display("xact backpressure: accepted=%0d ready_seen=%b", accepted, rdy_seen);

        xact("ILL_2F", 8'h2F, 5'd1, 5'd1, 5'd1, 32'h0000_0123, 32'h0, 1'b1, 1'b0);
        xact("ILL_90", 8'h90, 5'd1, 5'd1, 5'd1, 32'h0000_0123, 32'h0, 1'b1, 1'b0);
        xact("ILL_00", 8'h00, 5'd1, 5'd1, 5'd1, 32'h0000_0123, 32'h0, 1'b1, 1'b0);
        check_eq("err_count_3", 32'(err_count), 32'd3);

        // Stream 260 more illegal requests to reach saturation.
        accepted = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (accepted == 260) break;
            drive(8'hF0, 5'd2, 5'd2, 5'd2, 32'h0);
            in_valid = 1'b1;
            if (in_ready) accepted++;
        end
        in_valid = 1'b0;
        check_eq("sat_accepted", 32'(accepted), 32'd260);
        check_eq("err_count_sat", 32'(err_count), 32'h0000_00FF);
        $display("xact illegal_stream: accepted=%0d err_count=%0d", accepted, err_count);

        // Reset with two words buffered.
        @(negedge clk);
        out_ready = 1'b0;
        drive(8'h50, 5'd10, 5'd0, 5'd0, 32'h1234_5FFF);
        in_valid = 1'b1;
        @(negedge clk);
        drive(8'h51, 5'd2, 5'd0, 5'd0, 32'hABCD_E000);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("RS_full_ready", 32'(in_ready), 32'd0);
        check_eq("RS_head_word", out_instr, 32'h12345537);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("RS_out_valid", 32'(out_valid), 32'd0);
        check_eq("RS_err_count", 32'(err_count), 32'd0);
        check_eq("RS_in_ready", 32'(in_ready), 32'd1);
        check_eq("RS_out_instr", out_instr, 32'h0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("RS_no_stale", 32'(out_valid), 32'd0);
        end
        $display("xact reset_midstream: out_valid=%0d err_count=%0d", out_valid, err_count);
        xact("AUIPC", 8'h51, 5'd2, 5'd0, 5'd0, 32'hABCD_E000, 32'hABCDE117, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
